// File: rtl/instr_encoder_if.sv
// Bundle-in / word-out stream plus reject reporting for the Frost32 instruction encoder.
// Both streams use valid/ready: a transfer happens on a rising edge where valid && ready;
// the source holds its payload stable while valid && !ready, and ready never depends on valid.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_group;
  logic [3:0]            in_ra;
  logic [3:0]            in_rb;
  logic [3:0]            in_rc;
  logic [3:0]            in_opcode;
  logic [15:0]           in_imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  err_pulse;
  logic [1:0]            err_code;
  logic [15:0]           err_count;

  modport master (
    output in_valid, in_group, in_ra, in_rb, in_rc, in_opcode, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err_pulse, err_code, err_count
  );

  modport slave (
    input  in_valid, in_group, in_ra, in_rb, in_rc, in_opcode, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err_pulse, err_code, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded instruction bundles into Frost32 words, rejects illegal encodings and
// streams accepted words with sequential byte addresses through a 2-entry FIFO.
module instr_encoder #(
  parameter int ADDR_WIDTH = 32,
  parameter int BASE_ADDR  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  instr_encoder_if.slave  bus
);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

  logic [31:0]           instr_mem [2];
  logic [ADDR_WIDTH-1:0] addr_mem  [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [ADDR_WIDTH-1:0] next_addr;

  logic [31:0] enc_word;
  logic [1:0]  rej_code;
  logic        rejected;
  logic        fire;
  logic        push;
  logic        pop;

  logic        err_pulse_q;
  logic [1:0]  err_code_q;
  logic [15:0] err_count_q;

  always_comb begin
    enc_word = {bus.in_group, bus.in_ra, bus.in_rb, bus.in_rc, 12'h000, bus.in_opcode};
    rej_code = 2'd0;
    case (bus.in_group)
      4'd1, 4'd2: enc_word = {bus.in_group, bus.in_ra, bus.in_rb, bus.in_opcode, bus.in_imm};
      4'd5: enc_word = {bus.in_group, bus.in_ra, bus.in_rb, bus.in_rc,
                        (bus.in_opcode >= 4'd8) ? bus.in_imm[11:0] : 12'h000, bus.in_opcode};
      default: ;
    endcase
    // simm12 must sign-extend back to in_imm: bits 15..11 all equal.
    if (bus.in_group >= 4'd7)
      rej_code = 2'd1;
    else if ((((bus.in_group == 4'd2) || (bus.in_group == 4'd3) || (bus.in_group == 4'd4))
              && (bus.in_opcode >= 4'd10))
             || ((bus.in_group == 4'd6) && (bus.in_opcode >= 4'd7)))
      rej_code = 2'd2;
    else if ((bus.in_group == 4'd5) && (bus.in_opcode >= 4'd8)
             && !((bus.in_imm[15:11] == 5'h00) || (bus.in_imm[15:11] == 5'h1F)))
      rej_code = 2'd3;
  end

  assign rejected     = (rej_code != 2'd0);
  assign bus.in_ready = (count != 2'd2) && !clear;
  assign fire         = bus.in_valid && bus.in_ready;
  assign push         = fire && !rejected;
  assign pop          = (count != 2'd0) && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      next_addr <= BASE;
    end else if (clear) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      next_addr <= BASE;
    end else begin
      if (push) begin
        wr_ptr    <= ~wr_ptr;
        next_addr <= next_addr + STEP;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: the outputs are gated to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= enc_word;
      addr_mem[wr_ptr]  <= next_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'd0;
      err_count_q <= 16'h0000;
    end else begin
      err_pulse_q <= fire && rejected;
      if (fire && rejected) begin
        err_code_q <= rej_code;
        if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'h0001;
      end
    end
  end

  assign bus.out_valid = (count != 2'd0);
  assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr] : 32'h0000_0000;
  assign bus.out_addr  = bus.out_valid ? addr_mem[rd_ptr] : '0;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_code  = err_code_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table through a streaming sink, then
// back-pressure, clear, address wrap and asynchronous reset sequences.
module tb_instr_encoder;
  logic clk;
  logic rst;
  logic clear;

  instr_encoder_if #(.ADDR_WIDTH(32)) bus ();
  instr_encoder_if #(.ADDR_WIDTH(4))  wbus ();

  instr_encoder #(.ADDR_WIDTH(32), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus)
  );

  instr_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(8)) u_wrap (
    .clk(clk), .rst(rst), .clear(clear), .bus(wbus)
  );

  typedef struct {
    logic [3:0]  grp;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [3:0]  op;
    logic [15:0] imm;
    logic        ok;
    logic [31:0] instr;
    logic [1:0]  code;
  } vec_t;

  vec_t        vecs [16];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr;
  logic [15:0] exp_cnt;
  logic [1:0]  exp_code;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] grp, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rc, input logic [3:0] op, input logic [15:0] imm);
    bus.in_group  = grp;
    bus.in_ra     = ra;
    bus.in_rb     = rb;
    bus.in_rc     = rc;
    bus.in_opcode = op;
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
  endtask

  task automatic wdrive(input logic [3:0] ra, input logic [3:0] op);
    wbus.in_group  = 4'd0;
    wbus.in_ra     = ra;
    wbus.in_rb     = 4'd0;
    wbus.in_rc     = 4'd0;
    wbus.in_opcode = op;
    wbus.in_imm    = 16'h0000;
    wbus.in_valid  = 1'b1;
  endtask

  initial begin
    //            grp    ra     rb     rc     op     imm       ok    instr          code
    vecs[0]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 16'h0000, 1'b1, 32'h0123_0000, 2'd0};
    vecs[1]  = '{4'd1, 4'd4, 4'd5, 4'd9, 4'd0, 16'h1234, 1'b1, 32'h1450_1234, 2'd0};
    vecs[2]  = '{4'd5, 4'd1, 4'd2, 4'd0, 4'd8, 16'hFFFC, 1'b1, 32'h5120_FFC8, 2'd0};
    vecs[3]  = '{4'd5, 4'd1, 4'd2, 4'd0, 4'd8, 16'h0800, 1'b0, 32'h0,         2'd3};
    vecs[4]  = '{4'd3, 4'hA, 4'hB, 4'hC, 4'd9, 16'hFFFF, 1'b1, 32'h3ABC_0009, 2'd0};
    vecs[5]  = '{4'd2, 4'd1, 4'd2, 4'd7, 4'd1, 16'hFFFE, 1'b1, 32'h2121_FFFE, 2'd0};
    vecs[6]  = '{4'd2, 4'd1, 4'd2, 4'd0, 4'hA, 16'h0000, 1'b0, 32'h0,         2'd2};
    vecs[7]  = '{4'd7, 4'd1, 4'd2, 4'd3, 4'd0, 16'h0000, 1'b0, 32'h0,         2'd1};
    vecs[8]  = '{4'd6, 4'd1, 4'd2, 4'd3, 4'd6, 16'h0000, 1'b1, 32'h6123_0006, 2'd0};
    vecs[9]  = '{4'd6, 4'd1, 4'd2, 4'd3, 4'd7, 16'h0000, 1'b0, 32'h0,         2'd2};
    vecs[10] = '{4'd5, 4'd2, 4'd3, 4'd4, 4'd7, 16'h0800, 1'b1, 32'h5234_0007, 2'd0};
    vecs[11] = '{4'd4, 4'd1, 4'd1, 4'd1, 4'hA, 16'h0000, 1'b0, 32'h0,         2'd2};
    vecs[12] = '{4'd5, 4'd0, 4'd0, 4'd0, 4'hF, 16'hF800, 1'b1, 32'h5000_800F, 2'd0};
    vecs[13] = '{4'd1, 4'hF, 4'hF, 4'd5, 4'hF, 16'hFFFF, 1'b1, 32'h1FFF_FFFF, 2'd0};
    vecs[14] = '{4'd0, 4'hF, 4'hF, 4'hF, 4'hF, 16'hFFFF, 1'b1, 32'h0FFF_000F, 2'd0};
    vecs[15] = '{4'hF, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 32'h0,         2'd1};

    rst   = 1'b1;
    clear = 1'b0;
    drive(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000);
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    wbus.in_valid  = 1'b0;
    wbus.in_group  = 4'd0;
    wbus.in_ra     = 4'd0;
    wbus.in_rb     = 4'd0;
    wbus.in_rc     = 4'd0;
    wbus.in_opcode = 4'd0;
    wbus.in_imm    = 16'h0000;
    wbus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_err_pulse", bus.err_pulse, 0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_wrap_addr", wbus.out_addr, 0);
    tick();
    rst = 1'b0;

    // Address wrap on the 4-bit instance based at 8
    wdrive(4'd1, 4'd1);
    tick();
    chk("wrap_addr0", wbus.out_addr, 8);
    chk("wrap_instr0", wbus.out_instr, 32'h0100_0001);
    wdrive(4'd2, 4'd2);
    tick();
    chk("wrap_addr1", wbus.out_addr, 12);
    wdrive(4'd3, 4'd3);
    tick();
    chk("wrap_addr2", wbus.out_addr, 0);
    chk("wrap_instr2", wbus.out_instr, 32'h0300_0003);
    wbus.in_valid = 1'b0;
    tick();
    chk("wrap_drained", wbus.out_valid, 0);

    // Vector table, streamed back-to-back into an always-ready sink
    exp_addr = 32'd0;
    exp_cnt  = 16'd0;
    exp_code = 2'd0;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].grp, vecs[i].ra, vecs[i].rb, vecs[i].rc, vecs[i].op, vecs[i].imm);
      tick();
      if (vecs[i].ok) begin
        chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
        chk($sformatf("v%0d_instr", i), bus.out_instr, vecs[i].instr);
        chk($sformatf("v%0d_addr", i), bus.out_addr, exp_addr);
        chk($sformatf("v%0d_no_err", i), bus.err_pulse, 0);
        chk($sformatf("v%0d_code_held", i), bus.err_code, exp_code);
        exp_addr = exp_addr + 32'd4;
      end else begin
        exp_cnt  = exp_cnt + 16'd1;
        exp_code = vecs[i].code;
        chk($sformatf("v%0d_err_pulse", i), bus.err_pulse, 1);
        chk($sformatf("v%0d_err_code", i), bus.err_code, exp_code);
        chk($sformatf("v%0d_err_count", i), bus.err_count, exp_cnt);
        chk($sformatf("v%0d_no_out", i), bus.out_valid, 0);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    chk("err_pulse_one_cycle", bus.err_pulse, 0);

    clear = 1'b1;
    #1;
    chk("clear_blocks_ready", bus.in_ready, 0);
    tick();
    clear = 1'b0;

    // Back-pressure: two accepted, third waits, outputs held
    bus.out_ready = 1'b0;
    drive(4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 16'h0000);
    tick();
    chk("bp_a_valid", bus.out_valid, 1);
    chk("bp_a_instr", bus.out_instr, 32'h0123_0000);
    drive(4'd0, 4'd4, 4'd5, 4'd6, 4'd1, 16'h0000);
    tick();
    chk("bp_full_ready", bus.in_ready, 0);
    chk("bp_hold_instr1", bus.out_instr, 32'h0123_0000);
    drive(4'd0, 4'd7, 4'd8, 4'd9, 4'd2, 16'h0000);
    tick();
    chk("bp_hold_instr2", bus.out_instr, 32'h0123_0000);
    chk("bp_hold_addr2", bus.out_addr, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_b_instr", bus.out_instr, 32'h0456_0001);
    chk("bp_b_addr", bus.out_addr, 4);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_c_instr", bus.out_instr, 32'h0789_0002);
    chk("bp_c_addr", bus.out_addr, 8);
    tick();
    chk("bp_drained", bus.out_valid, 0);

    // Clear with a full FIFO and a bundle waiting
    bus.out_ready = 1'b0;
    drive(4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 16'h0000);
    tick();
    drive(4'd0, 4'd2, 4'd2, 4'd2, 4'd2, 16'h0000);
    tick();
    chk("clr_full_addr", bus.out_addr, 12);
    drive(4'd1, 4'd3, 4'd4, 4'd0, 4'd2, 16'hBEEF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_out_valid", bus.out_valid, 0);
    chk("clr_out_instr", bus.out_instr, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("clr_next_instr", bus.out_instr, 32'h1342_BEEF);
    chk("clr_next_addr", bus.out_addr, 0);
    tick();

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    drive(4'd4, 4'd5, 4'd6, 4'd7, 4'd3, 16'h0000);
    tick();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_instr", bus.out_instr, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_err_count", bus.err_count, 0);
    chk("arst_err_code", bus.err_code, 0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(4'd4, 4'd5, 4'd6, 4'd7, 4'd3, 16'h0000);
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_instr", bus.out_instr, 32'h4567_0003);
    chk("post_rst_addr", bus.out_addr, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
